// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a circular FIFO feeding a start/data/parity/stop framer.
// Frames leave back-to-back while tx_en is high and the FIFO holds data.
module uart_tx_fifo #(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          tx_en,
  input  logic                          ovf_clr,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done
);
  localparam int DIV    = CLOCK_RATE / BAUD_RATE;
  localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int BIT_W  = 4;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rd_data_reg;
  logic [ADDR_W-1:0]    wr_ptr_reg;
  logic [ADDR_W-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic                 overflow_reg;
  logic                 wr_accept;
  logic                 pop;

  // Framer state
  state_t               state_reg, state_next;
  logic [BAUD_W-1:0]    baud_reg, baud_next;
  logic [BIT_W-1:0]     bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_reg, par_next;
  logic                 tx_reg, tx_next;
  logic                 baud_last;

  assign full      = (count_reg == DEPTH_C);
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign wr_accept = wr_en && !full;
  assign tx        = tx_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign baud_last = (baud_reg == BAUD_LAST);

  // Storage has no reset so it maps onto block RAM; the popped word is captured with the pop.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_reg] <= wr_data;
    if (pop) rd_data_reg <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      if (pop) rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      case ({wr_accept, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      // A dropped write wins over a simultaneous clear.
      if (wr_en && full) overflow_reg <= 1'b1;
      else if (ovf_clr) overflow_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg + BAUD_W'(1);
    bit_next   = bit_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    tx_next    = tx_reg;
    pop        = 1'b0;
    tx_done    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        baud_next = '0;
        tx_next   = 1'b1;
        if (tx_en && !empty) begin
          pop        = 1'b1;
          state_next = ST_START;
          bit_next   = '0;
          par_next   = 1'b0;
          tx_next    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_last) begin
          state_next = ST_DATA;
          baud_next  = '0;
          bit_next   = '0;
          shift_next = rd_data_reg;
          tx_next    = rd_data_reg[0];
          par_next   = rd_data_reg[0];
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_next = '0;
          if (bit_reg == DATA_LAST) begin
            bit_next = '0;
            if (PARITY != 0) begin
              state_next = ST_PARITY;
              tx_next    = (PARITY == 2) ? par_reg : ~par_reg;
            end else begin
              state_next = ST_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            // shift_reg[0] is on the line; bit 1 goes out next
            bit_next   = bit_reg + BIT_W'(1);
            shift_next = shift_reg >> 1;
            tx_next    = shift_reg[1];
            par_next   = par_reg ^ shift_reg[1];
          end
        end
      end
      ST_PARITY: begin
        if (baud_last) begin
          state_next = ST_STOP;
          baud_next  = '0;
          bit_next   = '0;
          tx_next    = 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_next = '0;
          if (bit_reg == STOP_LAST) begin
            tx_done  = 1'b1;
            bit_next = '0;
            if (tx_en && !empty) begin
              pop        = 1'b1;
              state_next = ST_START;
              par_next   = 1'b0;
              tx_next    = 1'b0;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            bit_next = bit_reg + BIT_W'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
    end
  end

endmodule
